// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the intersection timer/request logic and the phase controller.
// The master side drives tick, night and pedestrian requests; the slave side drives the lamps.
interface traffic_phase_ctrl_if;
    logic       en;
    logic       night_mode;
    logic       ns_ped;
    logic       ew_ped;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       lamp_on;
    logic       ns_walk;
    logic       ew_walk;
    logic [3:0] phase;
    logic       phase_done;

    modport master (
        output en, night_mode, ns_ped, ew_ped,
        input  ns_light, ew_light, lamp_on, ns_walk, ew_walk, phase, phase_done
    );

    modport slave (
        input  en, night_mode, ns_ped, ew_ped,
        output ns_light, ew_light, lamp_on, ns_walk, ew_walk, phase, phase_done
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Four-way intersection phase controller with per-phase durations, all-red clearance,
// pedestrian truncation of the opposing green and a night flash mode.
module traffic_phase_ctrl #(
    parameter int CNT_W     = 8,
    parameter int GREEN_T   = 40,
    parameter int LEFT_T    = 20,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int MIN_GREEN = 10,
    parameter int FLASH_T   = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    traffic_phase_ctrl_if.slave bus
);

    // state     | meaning
    // NS_GREEN  | N/S through green, N/S walk lit
    // NS_Y      | N/S yellow after through green
    // AR1       | all-red clearance before E/W left
    // EW_LEFT   | E/W protected left
    // EW_LEFT_Y | E/W yellow after left
    // EW_GREEN  | E/W through green, E/W walk lit
    // EW_Y      | E/W yellow after through green
    // AR2       | all-red clearance before N/S left (also flash recovery)
    // NS_LEFT   | N/S protected left
    // NS_LEFT_Y | N/S yellow after left
    // FLASH     | night flash, N/S yellow and E/W red with pulsing lamp power
    typedef enum logic [3:0] {
        NS_GREEN  = 4'd0,
        NS_Y      = 4'd1,
        AR1       = 4'd2,
        EW_LEFT   = 4'd3,
        EW_LEFT_Y = 4'd4,
        EW_GREEN  = 4'd5,
        EW_Y      = 4'd6,
        AR2       = 4'd7,
        NS_LEFT   = 4'd8,
        NS_LEFT_Y = 4'd9,
        FLASH     = 4'd10
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'd0;
    localparam logic [1:0] L_YELLOW = 2'd1;
    localparam logic [1:0] L_RED    = 2'd2;
    localparam logic [1:0] L_LEFT   = 2'd3;

    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(LEFT_T - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] F_LAST   = CNT_W'(FLASH_T - 1);

    if (GREEN_T < 1 || LEFT_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 || MIN_GREEN < 1 ||
        FLASH_T < 1 || MIN_GREEN > GREEN_T ||
        GREEN_T >= (1 << CNT_W) || LEFT_T >= (1 << CNT_W) || YELLOW_T >= (1 << CNT_W) ||
        ALLRED_T >= (1 << CNT_W) || MIN_GREEN >= (1 << CNT_W) || FLASH_T >= (1 << CNT_W))
    begin : g_param_check
        $error("traffic_phase_ctrl: duration parameters out of range");
    end

    state_t           state;
    state_t           next_state;
    state_t           succ;
    logic [CNT_W-1:0] cnt;
    logic             advance;
    logic             illegal;
    logic             flash_wrap;
    logic             ns_pend;
    logic             ew_pend;
    logic             ns_req;
    logic             ew_req;
    logic [1:0]       ns_light_q;
    logic [1:0]       ew_light_q;
    logic             lamp_q;
    logic             ns_walk_q;
    logic             ew_walk_q;

    function automatic logic [3:0] lamps_of(input state_t s);
        case (s)
            NS_GREEN:         lamps_of = {L_GREEN,  L_RED};
            NS_Y:             lamps_of = {L_YELLOW, L_RED};
            EW_LEFT:          lamps_of = {L_RED,    L_LEFT};
            EW_LEFT_Y, EW_Y:  lamps_of = {L_RED,    L_YELLOW};
            EW_GREEN:         lamps_of = {L_RED,    L_GREEN};
            NS_LEFT:          lamps_of = {L_LEFT,   L_RED};
            NS_LEFT_Y, FLASH: lamps_of = {L_YELLOW, L_RED};
            default:          lamps_of = {L_RED,    L_RED};
        endcase
    endfunction

    // A live request counts the same as a latched one for truncating the opposing green.
    assign ns_req     = ns_pend | bus.ns_ped;
    assign ew_req     = ew_pend | bus.ew_ped;
    assign flash_wrap = (state == FLASH) && bus.en && (cnt == F_LAST);

    always_comb begin
        succ    = state;
        advance = 1'b0;
        illegal = 1'b0;
        case (state)
            NS_GREEN: begin
                succ    = NS_Y;
                advance = bus.en && ((cnt == G_LAST) || (ew_req && cnt >= MIN_LAST));
            end
            NS_Y: begin
                succ    = AR1;
                advance = bus.en && (cnt == Y_LAST);
            end
            AR1: begin
                succ    = bus.night_mode ? FLASH : EW_LEFT;
                advance = bus.en && (cnt == AR_LAST);
            end
            EW_LEFT: begin
                succ    = EW_LEFT_Y;
                advance = bus.en && (cnt == L_LAST);
            end
            EW_LEFT_Y: begin
                succ    = EW_GREEN;
                advance = bus.en && (cnt == Y_LAST);
            end
            EW_GREEN: begin
                succ    = EW_Y;
                advance = bus.en && ((cnt == G_LAST) || (ns_req && cnt >= MIN_LAST));
            end
            EW_Y: begin
                succ    = AR2;
                advance = bus.en && (cnt == Y_LAST);
            end
            AR2: begin
                succ    = bus.night_mode ? FLASH : NS_LEFT;
                advance = bus.en && (cnt == AR_LAST);
            end
            NS_LEFT: begin
                succ    = NS_LEFT_Y;
                advance = bus.en && (cnt == L_LAST);
            end
            NS_LEFT_Y: begin
                succ    = NS_GREEN;
                advance = bus.en && (cnt == Y_LAST);
            end
            FLASH: begin
                succ    = AR2;
                advance = bus.en && !bus.night_mode;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal)
            next_state = AR2;
        else if (advance)
            next_state = succ;
        else
            next_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NS_GREEN;
            cnt        <= '0;
            ns_light_q <= L_GREEN;
            ew_light_q <= L_RED;
            lamp_q     <= 1'b1;
            ns_walk_q  <= 1'b1;
            ew_walk_q  <= 1'b0;
            ns_pend    <= 1'b0;
            ew_pend    <= 1'b0;
        end else begin
            state <= next_state;

            // In FLASH the counter wraps every half-period instead of ending the phase.
            if (next_state != state)
                cnt <= '0;
            else if (bus.en)
                cnt <= flash_wrap ? '0 : cnt + 1'b1;

            {ns_light_q, ew_light_q} <= lamps_of(next_state);
            ns_walk_q <= (next_state == NS_GREEN);
            ew_walk_q <= (next_state == EW_GREEN);

            if (next_state != FLASH || state != FLASH)
                lamp_q <= 1'b1;
            else if (flash_wrap)
                lamp_q <= ~lamp_q;

            if (next_state == NS_GREEN && state != NS_GREEN)
                ns_pend <= 1'b0;
            else if (bus.ns_ped && state != NS_GREEN)
                ns_pend <= 1'b1;

            if (next_state == EW_GREEN && state != EW_GREEN)
                ew_pend <= 1'b0;
            else if (bus.ew_ped && state != EW_GREEN)
                ew_pend <= 1'b1;
        end
    end

    assign bus.ns_light   = ns_light_q;
    assign bus.ew_light   = ew_light_q;
    assign bus.lamp_on    = lamp_q;
    assign bus.ns_walk    = ns_walk_q;
    assign bus.ew_walk    = ew_walk_q;
    assign bus.phase      = state;
    assign bus.phase_done = advance;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus random traffic,
// all checked against a table-driven phase model of the intersection.
module tb_traffic_phase_ctrl;
    localparam int GREEN_T   = 40;
    localparam int LEFT_T    = 20;
    localparam int YELLOW_T  = 5;
    localparam int ALLRED_T  = 2;
    localparam int MIN_GREEN = 10;
    localparam int FLASH_T   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    traffic_phase_ctrl_if bus ();

    traffic_phase_ctrl #(
        .CNT_W(8), .GREEN_T(GREEN_T), .LEFT_T(LEFT_T), .YELLOW_T(YELLOW_T),
        .ALLRED_T(ALLRED_T), .MIN_GREEN(MIN_GREEN), .FLASH_T(FLASH_T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Phase table indexed by phase number: duration and lamp colours (G=0 Y=1 R=2 L=3).
    int         ph_dur[11] = '{GREEN_T, YELLOW_T, ALLRED_T, LEFT_T, YELLOW_T,
                               GREEN_T, YELLOW_T, ALLRED_T, LEFT_T, YELLOW_T, 0};
    logic [1:0] ph_ns[11]  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd1};
    logic [1:0] ph_ew[11]  = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};

    int          m_ph, m_el;
    bit          m_lamp, m_nsp, m_ewp;
    int          model_bad;
    logic [11:0] last_obs, last_exp;

    logic [3:0] o_phase;
    logic [1:0] o_ns, o_ew;
    logic       o_lamp, o_nsw, o_eww, o_done;
    logic       nm_lvl = 1'b0;
    logic       tog    = 1'b1;

    task automatic model_reset();
        m_ph = 0; m_el = 0; m_lamp = 1'b1; m_nsp = 1'b0; m_ewp = 1'b0;
    endtask

    // One clock: drive inputs, sample at negedge, compare to model, advance model.
    task automatic step(input logic e, input logic nm, input logic np, input logic ep);
        logic [11:0] obs, expv;
        bit done;
        int nxt;
        bus.en = e; bus.night_mode = nm; bus.ns_ped = np; bus.ew_ped = ep;
        @(negedge clk);
        o_phase = bus.phase; o_ns = bus.ns_light; o_ew = bus.ew_light;
        o_lamp = bus.lamp_on; o_nsw = bus.ns_walk; o_eww = bus.ew_walk; o_done = bus.phase_done;
        done = 1'b0;
        nxt  = m_ph;
        if (e) begin
            if (m_ph == 10) begin
                if (!nm) begin done = 1'b1; nxt = 7; end
            end else if ((m_el + 1 == ph_dur[m_ph]) ||
                         (m_ph == 0 && (m_ewp || ep) && m_el + 1 >= MIN_GREEN) ||
                         (m_ph == 5 && (m_nsp || np) && m_el + 1 >= MIN_GREEN)) begin
                done = 1'b1;
                nxt  = ((m_ph == 2 || m_ph == 7) && nm) ? 10 : (m_ph + 1) % 10;
            end
        end
        obs  = {o_phase, o_ns, o_ew, o_lamp, o_nsw, o_eww, o_done};
        expv = {4'(m_ph), ph_ns[m_ph], ph_ew[m_ph], m_lamp, m_ph == 0, m_ph == 5, done};
        if (obs !== expv) begin model_bad++; last_obs = obs; last_exp = expv; end
        if (np && m_ph != 0) m_nsp = 1'b1;
        if (ep && m_ph != 5) m_ewp = 1'b1;
        if (nxt == 0 && m_ph != 0) m_nsp = 1'b0;
        if (nxt == 5 && m_ph != 5) m_ewp = 1'b0;
        if (nxt != m_ph) begin
            m_el = 0; m_lamp = 1'b1;
        end else if (e) begin
            m_el++;
            if (m_ph == 10 && m_el == FLASH_T) begin m_el = 0; m_lamp = !m_lamp; end
        end
        m_ph = nxt;
        @(posedge clk); #1;
    endtask

    // Wall-clock length of the next occurrence of phase ph; -1 if it never completes.
    task automatic measure(input logic [3:0] ph, input bit alt, input int np_at, input int ep_at,
                           output int len);
        bit in_ph = 1'b0;
        logic e;
        len = 0;
        for (int k = 0; k < 600; k++) begin
            e = alt ? tog : 1'b1;
            tog = ~tog;
            step(e, nm_lvl, in_ph && len == np_at, in_ph && len == ep_at);
            if (o_phase == ph) begin
                in_ph = 1'b1;
                len++;
            end else if (in_ph) begin
                return;
            end
        end
        len = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.en = 1'b0; bus.night_mode = 1'b0; bus.ns_ped = 1'b0; bus.ew_ped = 1'b0;
        @(posedge clk); #1;
        model_reset();
        tog = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b1; bus.night_mode = 1'b0; bus.ns_ped = 1'b0; bus.ew_ped = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.phase !== 4'd0) begin n_bad++; $display("FAIL reset_phase got %0d want 0", bus.phase); end
        n_cmp++; if (bus.ns_light !== 2'd0) begin n_bad++; $display("FAIL reset_ns_light got %0d want 0", bus.ns_light); end
        n_cmp++; if (bus.ew_light !== 2'd2) begin n_bad++; $display("FAIL reset_ew_light got %0d want 2", bus.ew_light); end
        n_cmp++; if (bus.lamp_on !== 1'b1) begin n_bad++; $display("FAIL reset_lamp_on got %b want 1", bus.lamp_on); end
        n_cmp++; if (bus.ns_walk !== 1'b1) begin n_bad++; $display("FAIL reset_ns_walk got %b want 1", bus.ns_walk); end
        n_cmp++; if (bus.ew_walk !== 1'b0) begin n_bad++; $display("FAIL reset_ew_walk got %b want 0", bus.ew_walk); end
        n_cmp++; if (bus.phase_done !== 1'b0) begin n_bad++; $display("FAIL reset_phase_done got %b want 0", bus.phase_done); end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_full_cycle();
        int per[11];
        int exp_len[10] = '{40, 5, 2, 20, 5, 40, 5, 2, 20, 5};
        int dones = 0;
        model_bad = 0;
        foreach (per[i]) per[i] = 0;
        for (int k = 0; k < 144; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (o_phase <= 4'd10) per[o_phase]++;
            if (o_done === 1'b1) dones++;
        end
        for (int p = 0; p < 10; p++) begin
            n_cmp++;
            if (per[p] !== exp_len[p]) begin
                n_bad++; $display("FAIL cycle_len phase %0d got %0d want %0d", p, per[p], exp_len[p]);
            end
        end
        n_cmp++; if (dones !== 10) begin n_bad++; $display("FAIL cycle_done_pulses got %0d want 10", dones); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (o_phase !== 4'd0) begin n_bad++; $display("FAIL cycle_wrap got %0d want 0", o_phase); end
        n_cmp++; if (model_bad !== 0) begin n_bad++; $display("FAIL cycle_model %0d cycles differ, got %h want %h", model_bad, last_obs, last_exp); end
    endtask

    task automatic test_ped_early();
        int len;
        model_bad = 0;
        measure(4'd5, 1'b0, 3, -1, len);
        n_cmp++; if (len !== 10) begin n_bad++; $display("FAIL ped_early_len got %0d want 10", len); end
        n_cmp++; if (o_phase !== 4'd6) begin n_bad++; $display("FAIL ped_early_next got %0d want 6", o_phase); end
        measure(4'd5, 1'b0, -1, -1, len);
        n_cmp++; if (len !== 40) begin n_bad++; $display("FAIL ped_pend_cleared got %0d want 40", len); end
        n_cmp++; if (model_bad !== 0) begin n_bad++; $display("FAIL ped_early_model %0d cycles differ, got %h want %h", model_bad, last_obs, last_exp); end
    endtask

    task automatic test_ped_late();
        int len;
        model_bad = 0;
        measure(4'd5, 1'b0, 25, -1, len);
        n_cmp++; if (len !== 26) begin n_bad++; $display("FAIL ped_late_len got %0d want 26", len); end
        measure(4'd5, 1'b0, -1, 5, len);
        n_cmp++; if (len !== 40) begin n_bad++; $display("FAIL own_ped_ew_len got %0d want 40", len); end
        measure(4'd0, 1'b0, -1, -1, len);
        n_cmp++; if (len !== 40) begin n_bad++; $display("FAIL own_ped_ns_len got %0d want 40", len); end
        n_cmp++; if (model_bad !== 0) begin n_bad++; $display("FAIL ped_late_model %0d cycles differ, got %h want %h", model_bad, last_obs, last_exp); end
    endtask

    task automatic test_night();
        int k = -1;
        int bad = 0;
        logic [3:0] prev = 4'd0;
        logic [4:0] seq[4];
        do_reset();
        model_bad = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (o_phase == 4'd10) begin k = i; break; end
            prev = o_phase;
        end
        n_cmp++; if (k !== 47) begin n_bad++; $display("FAIL night_entry_cycle got %0d want 47", k); end
        n_cmp++; if (prev !== 4'd2) begin n_bad++; $display("FAIL night_entry_from got %0d want 2", prev); end
        if (o_lamp !== 1'b1 || o_ns !== 2'd1 || o_ew !== 2'd2) bad++;
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (o_phase !== 4'd10 || o_lamp !== ((i / 8) % 2 == 0) || o_ns !== 2'd1 || o_ew !== 2'd2) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL night_flash %0d cycles wrong, want 0", bad); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            seq[i] = {o_phase, o_done};
        end
        n_cmp++; if (seq[0] !== {4'd10, 1'b1}) begin n_bad++; $display("FAIL night_exit got %h want %h", seq[0], {4'd10, 1'b1}); end
        n_cmp++; if (seq[1] !== {4'd7, 1'b0}) begin n_bad++; $display("FAIL night_ar2_first got %h want %h", seq[1], {4'd7, 1'b0}); end
        n_cmp++; if (seq[2] !== {4'd7, 1'b1}) begin n_bad++; $display("FAIL night_ar2_last got %h want %h", seq[2], {4'd7, 1'b1}); end
        n_cmp++; if (seq[3] !== {4'd8, 1'b0}) begin n_bad++; $display("FAIL night_ns_left got %h want %h", seq[3], {4'd8, 1'b0}); end
        n_cmp++; if (model_bad !== 0) begin n_bad++; $display("FAIL night_model %0d cycles differ, got %h want %h", model_bad, last_obs, last_exp); end
    endtask

    task automatic test_en_toggle();
        int len;
        do_reset();
        model_bad = 0;
        measure(4'd1, 1'b1, -1, -1, len);
        n_cmp++; if (len !== 10) begin n_bad++; $display("FAIL en_toggle_ns_y got %0d want 10", len); end
        measure(4'd3, 1'b1, -1, -1, len);
        n_cmp++; if (len !== 40) begin n_bad++; $display("FAIL en_toggle_ew_left got %0d want 40", len); end
        n_cmp++; if (model_bad !== 0) begin n_bad++; $display("FAIL en_toggle_model %0d cycles differ, got %h want %h", model_bad, last_obs, last_exp); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int len;
        logic [10:0] got;
        do_reset();
        model_bad = 0;
        for (int i = 0; i < 200 && seen < 7; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (o_phase == 4'd3) seen++;
        end
        n_cmp++; if (seen !== 7) begin n_bad++; $display("FAIL mid_reset_reach got %0d want 7", seen); end
        #2 rst_n = 1'b0;
        #1 got = {bus.phase, bus.ns_light, bus.ew_light, bus.lamp_on, bus.ns_walk, bus.ew_walk};
        n_cmp++; if (got !== {4'd0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL mid_reset_outputs got %h want %h", got, {4'd0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        measure(4'd0, 1'b0, -1, -1, len);
        n_cmp++; if (len !== 40) begin n_bad++; $display("FAIL mid_reset_green got %0d want 40", len); end
        n_cmp++; if (model_bad !== 0) begin n_bad++; $display("FAIL mid_reset_model %0d cycles differ, got %h want %h", model_bad, last_obs, last_exp); end
    endtask

    task automatic test_random();
        int flashes = 0;
        do_reset();
        model_bad = 0;
        nm_lvl = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) nm_lvl = ~nm_lvl;
            step($urandom_range(0, 3) != 0, nm_lvl,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
            if (o_phase == 4'd10) flashes++;
        end
        nm_lvl = 1'b0;
        n_cmp++; if (model_bad !== 0) begin n_bad++; $display("FAIL random_model %0d cycles differ, got %h want %h", model_bad, last_obs, last_exp); end
        $display("random run: %0d cycles spent in flash", flashes);
    endtask

    initial begin
        bus.en = 1'b0; bus.night_mode = 1'b0; bus.ns_ped = 1'b0; bus.ew_ped = 1'b0;
        test_reset();
        test_full_cycle();
        test_ped_early();
        test_ped_late();
        test_night();
        test_en_toggle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
